// File: rtl/correlator_sequencer.sv
// Slot sequencer for a time-multiplexed correlator: read/write slot addresses, bank and block control.
// Define SEQ_OVERRUN_EN to latch a sticky overrun flag whenever a strobe is dropped.
module correlator_sequencer #(
  parameter int TRATE = 12,
  parameter int TBITS = 4,
  parameter int CBITS = 24,
  parameter int WLAT  = 3,
  parameter int DELAY = 3
) (
  input  logic             clk_x,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             strobe,
  input  logic [CBITS-1:0] blocksize,
  output logic             en,
  output logic             sw,
  output logic [TBITS-1:0] rd,
  output logic [TBITS-1:0] wr,
  output logic             bank,
  output logic             done,
  output logic             busy,
  output logic             overrun
);

  localparam int DW = (WLAT > 1) ? $clog2(WLAT) : 1;
  localparam logic [TBITS-1:0] LAST_SLOT  = TBITS'(TRATE - 1);
  localparam logic [DW-1:0]    LAST_DRAIN = DW'(WLAT - 1);
  localparam logic [DW-1:0]    PRE_DRAIN  = DW'(WLAT - 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [DW-1:0]    drain_cnt;
  logic [CBITS-1:0] sample_cnt;
  logic [CBITS-1:0] blk_q;
  logic [CBITS-1:0] blk_eff;
  logic             first_blk;
  logic             aborted;
  logic             final_pass;
  logic             last_pass;
  logic             drain_last;
  logic             start;
  logic [TBITS-1:0] wr_pipe [WLAT];

  // DELAY only matters to behavioural models; this core is zero-delay.
  if (DELAY < 0) begin : g_delay_param
  end

  always_comb begin
    blk_eff    = (blk_q == '0) ? CBITS'(1) : blk_q;
    last_pass  = (sample_cnt + CBITS'(1)) >= blk_eff;
    drain_last = (state == DRAIN) && (drain_cnt == LAST_DRAIN);
    start      = strobe && enable && ((state == IDLE) || drain_last);
  end

  // The trailing start block overrides the per-state assignments when a pass begins.
  always_ff @(posedge clk_x or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      en         <= 1'b0;
      sw         <= 1'b0;
      rd         <= '0;
      bank       <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      drain_cnt  <= '0;
      sample_cnt <= '0;
      blk_q      <= '0;
      first_blk  <= 1'b1;
      aborted    <= 1'b0;
      final_pass <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!enable) begin
            sample_cnt <= '0;
            first_blk  <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) aborted <= 1'b1;
          if (rd == LAST_SLOT) begin
            en        <= 1'b0;
            sw        <= 1'b0;
            rd        <= '0;
            state     <= DRAIN;
            drain_cnt <= '0;
            if (aborted || !enable) begin
              sample_cnt <= '0;
              first_blk  <= 1'b1;
              final_pass <= 1'b0;
            end else if (last_pass) begin
              sample_cnt <= '0;
              final_pass <= 1'b1;
              done       <= (WLAT == 1);
            end else begin
              sample_cnt <= sample_cnt + CBITS'(1);
              final_pass <= 1'b0;
            end
          end else begin
            rd <= rd + TBITS'(1);
          end
        end
        DRAIN: begin
          if (!enable) begin
            aborted    <= 1'b1;
            final_pass <= 1'b0;
            sample_cnt <= '0;
            first_blk  <= 1'b1;
          end else if ((WLAT > 1) && (drain_cnt == PRE_DRAIN) && final_pass) begin
            done <= 1'b1;
          end
          if (drain_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (start) begin
        state   <= RUN;
        en      <= 1'b1;
        rd      <= '0;
        busy    <= 1'b1;
        aborted <= 1'b0;
        if (sample_cnt == '0) begin
          sw    <= 1'b1;
          blk_q <= blocksize;
          if (first_blk) first_blk <= 1'b0;
          else           bank      <= ~bank;
        end else begin
          sw <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_x or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WLAT; i++) wr_pipe[i] <= '0;
    end else begin
      wr_pipe[0] <= rd;
      for (int i = 1; i < WLAT; i++) wr_pipe[i] <= wr_pipe[i-1];
    end
  end

  assign wr = wr_pipe[WLAT-1];

`ifdef SEQ_OVERRUN_EN
  logic dropped;
  assign dropped = strobe && ((state == RUN) || ((state == DRAIN) && !drain_last));

  always_ff @(posedge clk_x or negedge rst_n) begin
    if (!rst_n)       overrun <= 1'b0;
    else if (!enable) overrun <= 1'b0;
    else if (dropped) overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: doc/correlator_sequencer.md
CORRELATOR_SEQUENCER -- requirements
Module: correlator_sequencer

Interface
REQ-001 SHALL have parameter TRATE, default 12: number of time-multiplexed correlator slots per antenna sample.
REQ-002 SHALL have parameter TBITS, default 4: width of the slot addresses; 2^TBITS >= TRATE.
REQ-003 SHALL have parameter CBITS, default 24: width of the block-size value and of the sample counter.
REQ-004 SHALL have parameter WLAT, default 3: number of cycles from a read address to the matching write address.
REQ-005 SHALL have parameter DELAY, default 3: simulation-only assignment delay.
REQ-006 SHALL have port clk_x, input, 1 bit: single clock (correlator clock); one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port enable, input, 1 bit: correlation is permitted.
REQ-009 SHALL have port strobe, input, 1 bit: a new antenna sample is valid this cycle.
REQ-010 SHALL have port blocksize, input, CBITS bits: number of samples per bank.
REQ-011 SHALL have port en, output, 1 bit: correlator data valid.
REQ-012 SHALL have port sw, output, 1 bit: clear the accumulators on this pass.
REQ-013 SHALL have port rd, output, TBITS bits: accumulator read slot.
REQ-014 SHALL have port wr, output, TBITS bits: accumulator write slot.
REQ-015 SHALL have port bank, output, 1 bit: active bank.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when a block is complete.
REQ-017 SHALL have port busy, output, 1 bit: high while a pass or its write drain is in progress.
REQ-018 SHALL have port overrun, output, 1 bit: sticky flag set when a strobe is dropped.

Function
REQ-019 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE; IDLE->RUN on strobe&&enable; RUN->DRAIN after slot TRATE-1; DRAIN->IDLE after WLAT cycles, or DRAIN->RUN directly if strobe&&enable arrives in the last DRAIN cycle.
REQ-020 SHALL, for a strobe at cycle t, hold en=1 on cycles t+1..t+TRATE with rd=0,1,..,TRATE-1, then en=0 and rd=0.
REQ-021 SHALL drive wr as rd delayed exactly WLAT cycles through a shift register.
REQ-022 SHALL assert busy in RUN and DRAIN, and deassert it only in IDLE.
REQ-023 SHALL count completed passes; blocksize is latched at the first pass of each block, and a latched value of 0 is treated as 1.
REQ-024 SHALL hold sw=1 for every cycle of the first pass of each block, including the first pass after enable rises; sw=0 on all other cycles.
REQ-025 SHALL toggle bank on the first cycle of every block-start pass except the first block after enable rises.
REQ-026 SHALL pulse done for one cycle, in the cycle that wr presents slot TRATE-1 of the final pass of a block; the sample counter then returns to 0.
REQ-027 SHALL, on a strobe during RUN or DRAIN (other than the last DRAIN cycle), drop the strobe with no effect on en, rd, or the counter.
REQ-028 SHALL, on enable falling mid-pass, complete the current pass and drain, then go IDLE; SHALL reset the sample counter so that the next enabled strobe starts a new block with sw=1.
REQ-029 SHALL suppress done for any block that was aborted by enable falling.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force state=IDLE, en=0, sw=0, rd=0, wr=0 with all shift-register stages 0, bank=0, done=0, busy=0, overrun=0, sample counter=0 and latched blocksize=0.
REQ-031 SHALL, on reset release mid-pass, start no pass until a new strobe&&enable.

Configuration
REQ-032 SHALL use macro SEQ_OVERRUN_EN to select overrun detection.
REQ-033 SHALL, with SEQ_OVERRUN_EN defined, set overrun to 1 on any dropped strobe (REQ-027) while enable=1, and clear it only on reset or while enable=0.
REQ-034 SHALL, without SEQ_OVERRUN_EN defined, tie overrun to 0 and still drop such strobes silently.

Verification
REQ-035 SHALL cover: reset, enable=1, blocksize=2, strobe at cycle 10 -> en=1 on cycles 11..22, rd=0..11, wr=0..11 on cycles 14..25, sw=1 on cycles 11..22, bank=0.
REQ-036 SHALL cover: blocksize=2, strobes every 20 cycles -> sw on passes 1,3,5; bank toggles at pass 3 and pass 5; done one cycle when wr=11 on passes 2 and 4.
REQ-037 SHALL cover: a strobe 5 cycles after the first strobe -> strobe dropped, rd sequence unbroken, overrun=1 (macro defined) or 0 (macro undefined).
REQ-038 SHALL cover: blocksize=0 -> every pass has sw=1 and ends with done.
REQ-039 SHALL cover: enable low at rd=6 -> pass completes to rd=11, no done; re-enable with strobe -> sw=1 and overrun cleared.
REQ-040 SHALL cover: rst_n low at rd=4 -> all outputs 0 immediately, asynchronous to clk_x.
